// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit_if
// Brief  : Request/result bundle between the execute stage and muldiv_unit.
// Rev    : 1.0
// ============================================================================
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            stall;

   modport master (
      output req, kill, op, rs1_val, rs2_val,
      input  busy, done, result, stall
   );

   modport slave (
      input  req, kill, op, rs1_val, rs2_val,
      output busy, done, result, stall
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide unit (shift-add / restoring divide).
// Rev    : 1.0
// ============================================================================
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);

   localparam logic [CNT_W-1:0] c_ITERS = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(1);
   localparam logic [XLEN-1:0]  c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [2:0]        r_op;
   logic              r_neg_a;
   logic              r_neg_b;
   logic [XLEN-1:0]   r_b;
   logic [2*XLEN-1:0] r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   // Operand decode in IDLE
   logic            w_sign_a, w_sign_b, w_neg_a, w_neg_b;
   logic [XLEN-1:0] w_abs_a, w_abs_b;
   logic            w_div_zero, w_ovf;
   logic [XLEN-1:0] w_special;

   assign w_sign_a   = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
   assign w_sign_b   = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
   assign w_neg_a    = w_sign_a & bus.rs1_val[XLEN-1];
   assign w_neg_b    = w_sign_b & bus.rs2_val[XLEN-1];
   assign w_abs_a    = w_neg_a ? -bus.rs1_val : bus.rs1_val;
   assign w_abs_b    = w_neg_b ? -bus.rs2_val : bus.rs2_val;
   assign w_div_zero = bus.op[2] & (bus.rs2_val == '0);
   assign w_ovf      = bus.op[2] & ~bus.op[0] & (bus.rs1_val == c_MIN) & (bus.rs2_val == '1);
   // op[1] separates REM/REMU from DIV/DIVU
   assign w_special  = w_div_zero ? (bus.op[1] ? bus.rs1_val : '1)
                                  : (bus.op[1] ? '0 : c_MIN);

   // One iteration: multiply holds {partial_hi, multiplier}, divide holds {rem, dividend/quotient}
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_sh_rem;
   logic [XLEN:0]     w_trial;
   logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt;

   assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
   assign w_sh_rem  = r_acc[2*XLEN-1:XLEN-1];
   assign w_trial   = w_sh_rem - {1'b0, r_b};
   assign w_div_nxt = {(w_trial[XLEN] ? w_sh_rem[XLEN-1:0] : w_trial[XLEN-1:0]),
                       r_acc[XLEN-2:0], ~w_trial[XLEN]};
   assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

   // Sign fixup on the final iteration's value
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot, w_rem, w_final;

   assign w_prod = (r_neg_a ^ r_neg_b) ? -w_acc_nxt : w_acc_nxt;
   assign w_quot = (r_neg_a ^ r_neg_b) ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
   assign w_rem  = r_neg_a ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

   always_comb begin
      w_final = w_prod[XLEN-1:0];
      case (r_op)
         3'b000:                 w_final = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_final = w_quot;
         default:                w_final = w_rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req && !bus.kill) begin
                  r_op    <= bus.op;
                  r_neg_a <= w_neg_a;
                  r_neg_b <= w_neg_b;
                  r_cnt   <= c_ITERS;
                  if (bus.op[2]) begin
                     r_b   <= w_abs_b;
                     r_acc <= {{XLEN{1'b0}}, w_abs_a};
                  end else begin
                     r_b   <= w_abs_a;
                     r_acc <= {{XLEN{1'b0}}, w_abs_b};
                  end
                  if (w_div_zero || w_ovf) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_result <= w_special;
                  end else begin
                     r_state <= S_CALC;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               if (bus.kill) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt - c_LAST;
                  if (r_cnt == c_LAST) begin
                     r_state  <= S_DONE;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_result <= w_final;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.stall  = bus.req & ~r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Vector table, random ops vs. arithmetic model, kill/reset/back-to-back.
// Rev    : 1.0
// ============================================================================
module tb_muldiv_unit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   done_cnt;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.done === 1'b1) done_cnt = done_cnt + 1;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic from the instruction definitions
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sb; p = r; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; r = ua / ub; p = r; return p[31:0]; end
         3'd6: begin if (b == 0) return a; r = sa % sb; p = r; return p[31:0]; end
         default: begin if (b == 0) return a; r = ua % ub; p = r; return p[31:0]; end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0)) return 1;
      if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op in the current cycle; lat counts clock edges until done is seen
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit keep, input bit wiggle,
                         output logic [31:0] res, output int lat);
      int start;
      bit stall_ok;
      start      = done_cnt;
      stall_ok   = 1'b1;
      lat        = 0;
      bus.op      = f3;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.req     = 1'b1;
      #1;
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
         if (wiggle) begin
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom;
            bus.op      = 3'($urandom_range(0, 7));
            bus.req     = ($urandom_range(0, 3) != 0);
         end
         #1;
         if (bus.stall !== bus.req) stall_ok = 1'b0;
      end
      res = bus.result;
      chk("stall_before_done", 32'(stall_ok), 32'd1);
      chk("stall_in_done", 32'(bus.stall), 32'd0);
      if (!keep) bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("done_count", 32'(done_cnt - start), 32'd1);
   endtask

   vec_t        vecs[15];
   logic [31:0] res;
   int          lat;
   int          start;
   logic [2:0]  rop;
   logic [31:0] ra, rb;

   initial begin
      checks   = 0;
      errors   = 0;
      done_cnt = 0;
      rst         = 1'b1;
      bus.req     = 1'b0;
      bus.kill    = 1'b0;
      bus.op      = 3'd0;
      bus.rs1_val = '0;
      bus.rs2_val = '0;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[3]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33};
      vecs[7]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[8]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
      vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1};
      vecs[11] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        33};
      vecs[12] = '{3'd7, 32'hFFFF_FFFF, 32'd16,        32'd15,       33};
      vecs[13] = '{3'd4, 32'd0,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[14] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};

      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_result", bus.result, 32'd0);
      chk("reset_stall", 32'(bus.stall), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1, res, lat);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick_operand();
         rb  = pick_operand();
         run_op(rop, ra, rb, 1'b0, 1'b1, res, lat);
         chk($sformatf("rand%0d_op%0d_result", i, rop), res, ref_model(rop, ra, rb));
         chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(rop, ra, rb)));
      end

      // kill while idle with req present: nothing may be latched
      bus.op = 3'd0; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9;
      bus.req = 1'b1; bus.kill = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("idle_kill_busy", 32'(bus.busy), 32'd0);
      chk("idle_kill_done", 32'(bus.done), 32'd0);
      bus.req = 1'b0; bus.kill = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("idle_kill_busy_after", 32'(bus.busy), 32'd0);

      run_op(3'd0, 32'd5, 32'd6, 1'b0, 1'b0, res, lat);
      chk("pre_kill_result", res, 32'd30);

      // kill mid-calculation
      start = done_cnt;
      bus.op = 3'd5; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3; bus.req = 1'b1;
      repeat (10) begin @(posedge clk); @(negedge clk); end
      chk("kill_busy_before", 32'(bus.busy), 32'd1);
      bus.kill = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("kill_busy_after", 32'(bus.busy), 32'd0);
      chk("kill_done_after", 32'(bus.done), 32'd0);
      bus.kill = 1'b0; bus.req = 1'b0;
      repeat (40) @(negedge clk);
      chk("kill_no_done", 32'(done_cnt - start), 32'd0);
      chk("kill_result_kept", bus.result, 32'd30);

      // reset mid-calculation
      start = done_cnt;
      bus.op = 3'd0; bus.rs1_val = 32'd12345; bus.rs2_val = 32'd678; bus.req = 1'b1;
      repeat (10) begin @(posedge clk); @(negedge clk); end
      chk("rst_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_busy_now", 32'(bus.busy), 32'd0);
      chk("rst_done_now", 32'(bus.done), 32'd0);
      chk("rst_result_now", bus.result, 32'd0);
      @(negedge clk);
      bus.req = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_no_done", 32'(done_cnt - start), 32'd0);
      run_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b0, res, lat);
      chk("post_rst_mul", res, 32'd12);
      chk("post_rst_latency", 32'(lat), 32'd33);

      // back-to-back: req stays high across DONE
      run_op(3'd5, 32'd100, 32'd7, 1'b1, 1'b0, res, lat);
      chk("b2b_divu", res, 32'd14);
      chk("b2b_divu_latency", 32'(lat), 32'd33);
      run_op(3'd7, 32'd100, 32'd7, 1'b0, 1'b0, res, lat);
      chk("b2b_remu", res, 32'd2);
      chk("b2b_remu_latency", 32'(lat), 32'd33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
